// File: rtl/bus_arbiter.sv
// Purpose: round-robin sequencer for src->dst moves between bus registers on a shared bus.
// Latency: valid seen in IDLE -> o_req_ready 1 cycle later -> enables 2 cycles later.
// Backpressure: one transfer in flight; requests are ignored outside IDLE and held by requesters until ready.
// Option: define BUS_ARBITER_TURNAROUND_EN to add one bus-release (TURN) cycle after each DRIVE.
module bus_arbiter #(
  parameter int c_regs      = 4,
  parameter int c_reqs      = 2,
  parameter int c_sel_width = 2
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [c_reqs-1:0]               i_req_valid,
  input  logic [c_reqs*c_sel_width-1:0]   i_req_src,
  input  logic [c_reqs*c_sel_width-1:0]   i_req_dst,
  output logic [c_reqs-1:0]               o_req_ready,
  output logic [c_regs-1:0]               o_enable_out,
  output logic [c_regs-1:0]               o_enable_in,
  output logic                            o_busy
);

  localparam int c_ptr_width = (c_reqs > 1) ? $clog2(c_reqs) : 1;

  typedef logic [c_ptr_width-1:0] ptr_t;
  typedef logic [c_sel_width-1:0] sel_t;

`ifdef BUS_ARBITER_TURNAROUND_EN
  typedef enum logic [1:0] {IDLE, GRANT, DRIVE, TURN} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANT, DRIVE} state_t;
`endif

  state_t state, state_nxt;

  ptr_t ptr;          // round-robin pointer: first requester to consider
  ptr_t ptr_nxt;
  ptr_t winner;       // arbitration result from current inputs
  ptr_t winner_q;     // requester being served
  sel_t win_src, win_dst;
  sel_t src_q, dst_q;
  logic any_valid;

  logic [c_reqs-1:0] ready_nxt;
  logic [c_regs-1:0] enable_out_nxt, enable_in_nxt;
  logic              busy_nxt;
  logic              src_ok, dst_ok, distinct;

  // Round-robin pick: lowest valid index at/after ptr, else lowest valid index below ptr.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    win_src   = '0;
    win_dst   = '0;
    for (int r = c_reqs - 1; r >= 0; r--) begin
      if (i_req_valid[r] && (r < int'(ptr))) begin
        any_valid = 1'b1;
        winner    = ptr_t'(r);
        win_src   = i_req_src[r*c_sel_width +: c_sel_width];
        win_dst   = i_req_dst[r*c_sel_width +: c_sel_width];
      end
    end
    for (int r = c_reqs - 1; r >= 0; r--) begin
      if (i_req_valid[r] && (r >= int'(ptr))) begin
        any_valid = 1'b1;
        winner    = ptr_t'(r);
        win_src   = i_req_src[r*c_sel_width +: c_sel_width];
        win_dst   = i_req_dst[r*c_sel_width +: c_sel_width];
      end
    end
  end

  // Pointer advances to the requester after the one being granted, wrapping at c_reqs.
  always_comb begin
    if (int'(winner_q) >= c_reqs - 1) ptr_nxt = '0;
    else                              ptr_nxt = winner_q + ptr_t'(1);
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: IDLE -> GRANT -> DRIVE -> (TURN ->) IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = GRANT;
      GRANT:   state_nxt = DRIVE;
`ifdef BUS_ARBITER_TURNAROUND_EN
      DRIVE:   state_nxt = TURN;
      TURN:    state_nxt = IDLE;
`else
      DRIVE:   state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winning request on leaving IDLE; move the pointer during GRANT.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ptr      <= '0;
      winner_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
    end else begin
      if (state == IDLE && any_valid) begin
        winner_q <= winner;
        src_q    <= win_src;
        dst_q    <= win_dst;
      end
      if (state == GRANT) ptr <= ptr_nxt;
    end
  end

  // Output decode for the upcoming state; a bad or equal index keeps the enables quiet,
  // and an unusable source also blocks the load so nobody captures a floating bus.
  always_comb begin
    ready_nxt      = '0;
    enable_out_nxt = '0;
    enable_in_nxt  = '0;
    busy_nxt       = (state_nxt != IDLE);
    src_ok         = int'(src_q) < c_regs;
    dst_ok         = int'(dst_q) < c_regs;
    distinct       = (src_q != dst_q);
    for (int r = 0; r < c_reqs; r++) begin
      if (state_nxt == GRANT && int'(winner) == r) ready_nxt[r] = 1'b1;
    end
    for (int r = 0; r < c_regs; r++) begin
      if (state_nxt == DRIVE && src_ok && distinct && int'(src_q) == r)
        enable_out_nxt[r] = 1'b1;
      if (state_nxt == DRIVE && src_ok && dst_ok && distinct && int'(dst_q) == r)
        enable_in_nxt[r] = 1'b1;
    end
  end

  // Output register: nothing combinational reaches the ports.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_req_ready  <= '0;
      o_enable_out <= '0;
      o_enable_in  <= '0;
      o_busy       <= 1'b0;
    end else begin
      o_req_ready  <= ready_nxt;
      o_enable_out <= enable_out_nxt;
      o_enable_in  <= enable_in_nxt;
      o_busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a small model of the bus registers behind it.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
// Transfer spacing follows BUS_ARBITER_TURNAROUND_EN (4 cycles with it, 3 without).
module tb_bus_arbiter;

  localparam int c_regs      = 4;
  localparam int c_reqs      = 2;
  localparam int c_sel_width = 3;
`ifdef BUS_ARBITER_TURNAROUND_EN
  localparam int period = 4;
`else
  localparam int period = 3;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [c_reqs-1:0]             req_valid;
  logic [c_reqs*c_sel_width-1:0] req_src;
  logic [c_reqs*c_sel_width-1:0] req_dst;
  logic [c_reqs-1:0]             req_ready;
  logic [c_regs-1:0]             enable_out;
  logic [c_regs-1:0]             enable_in;
  logic                          busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit inv_on = 1'b0;

  logic [7:0] regs [c_regs];
  logic [7:0] bus;

  always #5 clock = ~clock;

  bus_arbiter #(.c_regs(c_regs), .c_reqs(c_reqs), .c_sel_width(c_sel_width)) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .i_req_src    (req_src),
    .i_req_dst    (req_dst),
    .o_req_ready  (req_ready),
    .o_enable_out (enable_out),
    .o_enable_in  (enable_in),
    .o_busy       (busy)
  );

  // Shared bus: value of whichever register has its output enabled.
  always_comb begin
    bus = '0;
    for (int r = 0; r < c_regs; r++) if (enable_out[r]) bus = bus | regs[r];
  end

  // Bus registers: preset during reset, load the bus when enabled.
  always @(posedge clock) begin
    if (reset) begin
      regs[0] <= 8'h5A;
      regs[1] <= 8'hBD;
      regs[2] <= 8'h00;
      regs[3] <= 8'hC3;
    end else begin
      for (int r = 0; r < c_regs; r++) if (enable_in[r]) regs[r] <= bus;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] rdy, input logic [3:0] eo,
                            input logic [3:0] ei, input logic bsy);
    check({tag, ".ready"},      32'(req_ready),  32'(rdy));
    check({tag, ".enable_out"}, 32'(enable_out), 32'(eo));
    check({tag, ".enable_in"},  32'(enable_in),  32'(ei));
    check({tag, ".busy"},       32'(busy),       32'(bsy));
  endtask

  task automatic set_req(input int k, input logic [2:0] s, input logic [2:0] d);
    req_src[k*c_sel_width +: c_sel_width] = s;
    req_dst[k*c_sel_width +: c_sel_width] = d;
  endtask

  // Never more than one driver, one loader or one grant at a time.
  always @(negedge clock) begin
    if (inv_on) begin
      check("onehot_out",   32'($countones(enable_out) <= 1), 32'd1);
      check("onehot_in",    32'($countones(enable_in) <= 1),  32'd1);
      check("onehot_ready", 32'($countones(req_ready) <= 1),  32'd1);
    end
  end

  initial begin
    logic [1:0] e_rdy;
    logic [3:0] e_eo, e_ei;
    int off, g;

    req_valid = '0;
    req_src   = '0;
    req_dst   = '0;

    // Reset held with both requests up: nothing granted.
    reset     = 1'b1;
    req_valid = 2'b11;
    tick(2);
    expect_out("reset", 2'b00, 4'h0, 4'h0, 1'b0);
    req_valid = 2'b00;
    reset     = 1'b0;
    tick();
    expect_out("idle", 2'b00, 4'h0, 4'h0, 1'b0);
    inv_on = 1'b1;

    // Single transfer reg1 -> reg2.
    set_req(0, 3'd1, 3'd2);
    req_valid = 2'b01;
    tick();
    expect_out("single_grant", 2'b01, 4'h0, 4'h0, 1'b1);
    req_valid = 2'b00;
    tick();
    expect_out("single_drive", 2'b00, 4'b0010, 4'b0100, 1'b1);
    tick(period - 2);
    expect_out("single_done", 2'b00, 4'h0, 4'h0, 1'b0);
    check("single_load", 32'(regs[2]), 32'hBD);

    // Contention from pointer 0: grants alternate, one transfer per period.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 3'd0, 3'd1);
    set_req(1, 3'd3, 3'd2);
    req_valid = 2'b11;
    for (int i = 1; i <= 4 * period; i++) begin
      tick();
      off   = (i - 1) % period;
      g     = (i - 1) / period;
      e_rdy = (off == 0) ? ((g % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      e_eo  = (off == 1) ? ((g % 2 == 0) ? 4'b0001 : 4'b1000) : 4'b0000;
      e_ei  = (off == 1) ? ((g % 2 == 0) ? 4'b0010 : 4'b0100) : 4'b0000;
      expect_out($sformatf("rr%0d", i), e_rdy, e_eo, e_ei, off != period - 1);
    end
    req_valid = 2'b00;
    tick();
    expect_out("rr_quiet", 2'b00, 4'h0, 4'h0, 1'b0);

    // src == dst: accepted, no enables.
    set_req(0, 3'd3, 3'd3);
    req_valid = 2'b01;
    tick();
    expect_out("same_grant", 2'b01, 4'h0, 4'h0, 1'b1);
    req_valid = 2'b00;
    tick();
    expect_out("same_drive", 2'b00, 4'h0, 4'h0, 1'b1);
    tick(period - 2);

    // Out-of-range source: both enables suppressed.
    set_req(1, 3'd5, 3'd0);
    req_valid = 2'b10;
    tick();
    expect_out("oor_grant", 2'b10, 4'h0, 4'h0, 1'b1);
    req_valid = 2'b00;
    tick();
    expect_out("oor_drive", 2'b00, 4'h0, 4'h0, 1'b1);
    tick(period - 2);

    // Out-of-range destination: source still drives, nothing loads.
    set_req(0, 3'd2, 3'd7);
    req_valid = 2'b01;
    tick();
    expect_out("oordst_grant", 2'b01, 4'h0, 4'h0, 1'b1);
    req_valid = 2'b00;
    tick();
    expect_out("oordst_drive", 2'b00, 4'b0100, 4'h0, 1'b1);

    // Request raised while busy, withdrawn once back in IDLE: no grant.
    req_valid = 2'b10;
    tick(period - 2);
    req_valid = 2'b00;
    tick();
    expect_out("withdraw", 2'b00, 4'h0, 4'h0, 1'b0);

    // Reset during DRIVE clears enables and the pointer (pointer is 1 here).
    set_req(0, 3'd1, 3'd2);
    req_valid = 2'b01;
    tick();
    expect_out("rst_grant", 2'b01, 4'h0, 4'h0, 1'b1);
    req_valid = 2'b00;
    tick();
    expect_out("rst_predrive", 2'b00, 4'b0010, 4'b0100, 1'b1);
    reset = 1'b1;
    tick();
    expect_out("rst_drive", 2'b00, 4'h0, 4'h0, 1'b0);
    reset     = 1'b0;
    req_valid = 2'b11;
    tick();
    expect_out("rst_ptr", 2'b01, 4'h0, 4'h0, 1'b1);
    req_valid = 2'b00;
    tick();
    expect_out("rst_ptr_drive", 2'b00, 4'b0010, 4'b0100, 1'b1);
    tick(period - 2);

    // Reset during GRANT: the transfer is dropped, not replayed.
    set_req(1, 3'd3, 3'd0);
    req_valid = 2'b10;
    tick();
    expect_out("rstg_grant", 2'b10, 4'h0, 4'h0, 1'b1);
    req_valid = 2'b00;
    reset     = 1'b1;
    tick();
    expect_out("rstg_reset", 2'b00, 4'h0, 4'h0, 1'b0);
    reset = 1'b0;
    tick();
    expect_out("rstg_no_replay", 2'b00, 4'h0, 4'h0, 1'b0);
    tick();
    expect_out("rstg_still_idle", 2'b00, 4'h0, 4'h0, 1'b0);

    inv_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
